// File: rtl/sound_out_resampler.sv
// Zero-order-hold resampler with ramped volume gain feeding a small FWFT output FIFO.
// Tick to FIFO write is 4 cycles; on a full FIFO the new sample is dropped and counted.
module sound_out_resampler #(
  parameter int CLK_HZ     = 54000000,
  parameter int OUT_HZ     = 48000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_logic,
  input  logic        system_reset,
  input  logic [15:0] audio_l_i,
  input  logic [15:0] audio_r_i,
  input  logic        in_valid_i,
  input  logic [3:0]  volume_i,
  input  logic        mute_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_l_o,
  output logic [15:0] out_r_o,
  output logic [7:0]  drop_cnt_o,
  output logic [8:0]  gain_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] CLK_INC = 32'(CLK_HZ);
  localparam logic [31:0] OUT_INC = 32'(OUT_HZ);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, PUSH} state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_l_q, hold_r_q, snap_l_q, snap_r_q, res_l_q, res_r_q;
  logic [15:0] last_l_q, last_r_q;
  logic [31:0] phase_q, phase_d, phase_sum;
  logic [8:0]  gain_q, gain_d, target;
  logic [7:0]  drop_q;
  logic [15:0] mem_l_q [FIFO_DEPTH];
  logic [15:0] mem_r_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic        tick, push_req, fifo_full, fifo_empty, pop, wr_en, drop;
  logic [15:0] mul_a, mul_res;
  logic [23:0] prod;

  assign phase_sum = phase_q + OUT_INC;
  assign tick      = (phase_sum >= CLK_INC);
  assign phase_d   = tick ? (phase_sum - CLK_INC) : phase_sum;

  assign target = mute_i ? 9'd0 : (({5'd0, volume_i} + 9'd1) << 4);

  always_comb begin
    gain_d = gain_q;
    if (tick) begin
      if (gain_q < target)      gain_d = gain_q + 9'd1;
      else if (gain_q > target) gain_d = gain_q - 9'd1;
    end
  end

  // One multiplier shared by both channels; low 24 bits of the sign-extended product suffice.
  assign mul_a   = (state_q == MUL_R) ? snap_r_q : snap_l_q;
  assign prod    = {{8{mul_a[15]}}, mul_a} * {15'd0, gain_q};
  assign mul_res = 16'(prod >> 8);

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    case (state_q)
      IDLE:    if (tick) state_d = MUL_L;
      MUL_L:   state_d = MUL_R;
      MUL_R:   state_d = PUSH;
      PUSH: begin
        push_req = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign pop        = out_ready_i & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_en      = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_logic or posedge system_reset) begin
    if (system_reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      gain_q   <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      snap_l_q <= '0;
      snap_r_q <= '0;
      res_l_q  <= '0;
      res_r_q  <= '0;
      last_l_q <= '0;
      last_r_q <= '0;
      drop_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l_q[i] <= '0;
        mem_r_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gain_q  <= gain_d;
      count_q <= count_d;
      if (in_valid_i) begin
        hold_l_q <= audio_l_i;
        hold_r_q <= audio_r_i;
      end
      if (state_q == IDLE && tick) begin
        snap_l_q <= hold_l_q;
        snap_r_q <= hold_r_q;
      end
      if (state_q == MUL_L) res_l_q <= mul_res;
      if (state_q == MUL_R) res_r_q <= mul_res;
      if (wr_en) begin
        mem_l_q[wr_ptr_q] <= res_l_q;
        mem_r_q[wr_ptr_q] <= res_r_q;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        last_l_q <= mem_l_q[rd_ptr_q];
        last_r_q <= mem_r_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign out_valid_o = ~fifo_empty;
  assign out_l_o     = fifo_empty ? last_l_q : mem_l_q[rd_ptr_q];
  assign out_r_o     = fifo_empty ? last_r_q : mem_r_q[rd_ptr_q];
  assign drop_cnt_o  = drop_q;
  assign gain_o      = gain_q;

endmodule

// File: tb/tb_sound_out_resampler.sv
// Scoreboard bench: expected samples are queued by transfer index, a monitor checks each transfer.
module tb_sound_out_resampler;

  localparam int CLK_HZ = 1000;
  localparam int OUT_HZ = 120;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] audio_l = '0, audio_r = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  volume = 4'd15;
  logic        mute = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] out_l, out_r;
  logic [7:0]  drop_cnt;
  logic [8:0]  gain;

  sound_out_resampler #(.CLK_HZ(CLK_HZ), .OUT_HZ(OUT_HZ), .FIFO_DEPTH(DEPTH)) dut (
    .clk_logic(clk), .system_reset(rst),
    .audio_l_i(audio_l), .audio_r_i(audio_r), .in_valid_i(in_valid),
    .volume_i(volume), .mute_i(mute),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_l_o(out_l), .out_r_o(out_r),
    .drop_cnt_o(drop_cnt), .gain_o(gain)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; logic [15:0] l; logic [15:0] r;} exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int idx, input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    e.idx = idx; e.l = l; e.r = r;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      xfer_cnt = xfer_cnt + 1;
      if (exp_q.size() > 0 && exp_q[0].idx == xfer_cnt) begin
        e = exp_q.pop_front();
        chk($sformatf("sample%0d_l", e.idx), {16'd0, out_l}, {16'd0, e.l});
        chk($sformatf("sample%0d_r", e.idx), {16'd0, out_r}, {16'd0, e.r});
      end
    end
  end

  task automatic wait_cnt(input int target, input int budget, input string name);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (xfer_cnt < target) chk({name, "_timeout"}, xfer_cnt, target);
  endtask

  task automatic wait_next();
    int c = xfer_cnt;
    wait_cnt(c + 1, 60, "next_xfer");
  endtask

  task automatic pulse_in(input logic [15:0] l, input logic [15:0] r);
    audio_l  = l;
    audio_r  = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int base, s, n;
    logic [15:0] hl, hr;
    logic bad;

    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_l", out_l, 0);
    chk("rst_r", out_r, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_gain", gain, 0);

    // Ramp-up from gain 0 to unity; sample n uses gain n.
    rst = 1'b0;
    pulse_in(16'h4000, 16'hC000);
    push_exp(1,   16'h0040, 16'hFFC0);
    push_exp(2,   16'h0080, 16'hFF80);
    push_exp(128, 16'h2000, 16'hE000);
    push_exp(256, 16'h4000, 16'hC000);
    push_exp(260, 16'h4000, 16'hC000);
    wait_cnt(260, 3000, "ramp_up");
    chk("gain_unity", gain, 256);

    // Volume 15 -> 7: gain steps down to 128.
    wait_next();
    volume = 4'd7;
    base = xfer_cnt;
    push_exp(base + 1,   16'h3FC0, 16'hC040);
    push_exp(base + 64,  16'h3000, 16'hD000);
    push_exp(base + 128, 16'h2000, 16'hE000);
    push_exp(base + 140, 16'h2000, 16'hE000);
    wait_cnt(base + 140, 1500, "ramp_down");
    chk("gain_half", gain, 128);

    // Rate: any 10000-cycle window holds exactly 1200 ticks at 120/1000.
    @(posedge clk);
    s = xfer_cnt;
    repeat (10000) @(posedge clk);
    chk("rate_window", xfer_cnt - s, 1200);

    // Backpressure with a rising ramp so samples are distinct (gain 129, 130, ...).
    @(negedge clk);
    wait_next();
    out_ready = 1'b0;
    volume    = 4'd15;
    base      = xfer_cnt;
    n = 0;
    while (drop_cnt < 8'd6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("bp_drop", drop_cnt, 6);
    chk("bp_valid", out_valid, 1);
    hl = out_l;
    hr = out_r;
    chk("bp_head_l", hl, 16'h2040);
    chk("bp_head_r", hr, 16'hDFC0);
    @(negedge clk);
    chk("bp_stable_l", out_l, 16'h2040);
    chk("bp_stable_r", out_r, 16'hDFC0);
    push_exp(base + 1, 16'h2040, 16'hDFC0);
    push_exp(base + 2, 16'h2080, 16'hDF80);
    push_exp(base + 3, 16'h20C0, 16'hDF40);
    push_exp(base + 4, 16'h2100, 16'hDF00);
    push_exp(base + 5, 16'h22C0, 16'hDD40);
    out_ready = 1'b1;
    wait_cnt(base + 5, 100, "drain");
    chk("bp_drop_after", drop_cnt, 6);

    // Mute ramp with input -1/+1: floor rounding gives -1 and 0 until gain hits 0.
    n = 0;
    while (gain !== 9'd256 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("gain_back_unity", gain, 256);
    wait_next();
    mute = 1'b1;
    base = xfer_cnt;
    pulse_in(16'hFFFF, 16'h0001);
    push_exp(base + 1,   16'hFFFF, 16'h0000);
    push_exp(base + 255, 16'hFFFF, 16'h0000);
    push_exp(base + 256, 16'h0000, 16'h0000);
    push_exp(base + 258, 16'h0000, 16'h0000);
    wait_cnt(base + 258, 3000, "mute_ramp");
    chk("gain_muted", gain, 0);

    // Fresh reset gives a known tick schedule: ticks in cycles 9, 17, 25; MUL_R in cycle 27.
    chk("queue_empty_pre_reset", exp_q.size(), 0);
    @(negedge clk);
    rst       = 1'b1;
    mute      = 1'b0;
    volume    = 4'd15;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulse_in(16'h4000, 16'hC000);
    repeat (25) @(posedge clk);
    #2;
    chk("pre_reset_gain", gain, 3);
    chk("pre_reset_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_drop", drop_cnt, 0);
    chk("async_rst_gain", gain, 0);
    chk("async_rst_l", out_l, 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    base      = xfer_cnt;
    push_exp(base + 1, 16'h0000, 16'h0000);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    chk("no_stale_after_reset", bad, 0);
    wait_cnt(base + 1, 60, "post_reset_sample");

    chk("queue_empty_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_out_resampler.md
Name: sound_out_resampler

Overview:
- Downstream stage of the IIgs GLU/DOC audio path: consumes the signed 16-bit stereo mix and the GLU volume nibble.
- Resamples the mix to a fixed output rate by zero-order hold and applies a ramped, zipper-free volume gain.
- Buffers the results in a small FIFO.
- Delivers samples over a valid/ready handshake to the HDMI/I2S audio sink.

Parameters:
- CLK_HZ, 54000000, frequency of clk_logic in Hz.
- OUT_HZ, 48000, output sample rate in Hz; must be < CLK_HZ/8.
- FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16.

Ports:
- clk_logic  input  1  sole clock.
- system_reset  input  1  asynchronous, active-high reset.
- audio_l_i  input  16  signed left mix from GLU.
- audio_r_i  input  16  signed right mix from GLU.
- in_valid_i  input  1  one-cycle pulse: audio_l_i/audio_r_i carry a new mix sample.
- volume_i  input  4  GLU volume, 0 = quietest, 15 = loudest.
- mute_i  input  1  force target gain to 0.
- out_valid_o  output  1  FIFO head holds a sample.
- out_ready_i  input  1  sink accepts the head sample.
- out_l_o  output  16  signed left output sample.
- out_r_o  output  16  signed right output sample.
- drop_cnt_o  output  8  saturating count of samples dropped on FIFO full.
- gain_o  output  9  current ramped gain, for debug.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears all state.
  - out_valid_o=0, out_l_o=0, out_r_o=0, drop_cnt_o=0, gain_o=0, FIFO empty, FSM in IDLE, phase accumulator=0.
  - Deassertion resumes normally. A reset mid-operation discards any in-flight sample and all FIFO contents.
- Input hold:
  - On in_valid_i, hold_l/hold_r latch audio_l_i/audio_r_i.
  - With no in_valid_i, the previous held values persist (zero-order hold).
- Tick generator:
  - A 32-bit phase accumulator adds OUT_HZ every cycle.
  - When the sum >= CLK_HZ, it subtracts CLK_HZ and asserts tick for one cycle.
  - Long-run tick rate is exactly OUT_HZ; no drift.
- Target gain:
  - 0 if mute_i=1, else (volume_i+1)*16. Volume 15 gives 256 = unity; volume 0 gives 16.
- Gain ramp:
  - On each tick, before the multiply, gain moves by 1 toward target.
  - If |target-gain| < 1, gain equals target.
  - A full 0->256 ramp therefore takes 256 ticks.
- FSM with one shared 16x9 signed multiplier:
  - IDLE: on tick, snapshot hold_l/hold_r (an in_valid_i in the same cycle as tick is NOT included; it appears at the next tick). Go to MUL_L.
  - MUL_L: prod = snap_l * gain (gain as unsigned 9-bit); res_l = prod >>> 8, truncated toward -inf. Go to MUL_R.
  - MUL_R: same for the right channel. Go to PUSH.
  - PUSH:
    - If the FIFO is not full, write {res_l,res_r}.
    - If the FIFO is full, drop the sample and increment drop_cnt_o, saturating at 255.
    - If the sink pops in this same cycle while full, the pop frees the slot and the write succeeds with no drop.
    - Go to IDLE.
  - A tick arriving while not in IDLE cannot occur given the OUT_HZ constraint. If it does, it is ignored.
- Arithmetic: gain <= 256, so |res| <= |in|. No saturation logic; -32768 at gain 256 yields -32768.
- Latency: tick to FIFO write is 4 cycles. With the FIFO empty, out_valid_o rises in the cycle after the write.
- FIFO and handshake:
  - First-word-fall-through; out_l_o/out_r_o show the head entry.
  - Transfer occurs on out_valid_o & out_ready_i.
  - out_valid_o and the data are stable while out_ready_i is low.
  - A simultaneous push and pop keeps the occupancy unchanged.
  - When empty, out_l_o/out_r_o keep their last value (0 after reset).
- gain_o always reflects the current ramp register.

Test Plan:
- Reset, then volume_i=15, in_valid_i pulse with L=0x4000, R=0xC000, out_ready_i=1 -> gain_o counts 0->256 over 256 ticks; the first sample after gain reaches 256 is L=0x4000, R=0xC000.
- Gain held at 256, then volume_i changes 15->7 -> gain decreases by 1 per tick to 128; at 128, L=0x4000 gives 0x2000 and R=0xC000 gives 0xE000.
- CLK_HZ=54000000, OUT_HZ=48000, run 54,000,000 cycles -> exactly 48000 out_valid_o transfers with out_ready_i=1.
- out_ready_i=0 for 10 ticks, FIFO_DEPTH=4 -> 4 entries held and stable, drop_cnt_o=6; raise out_ready_i -> the 4 oldest samples drain in order.
- mute_i=1 from gain 256 -> gain ramps to 0 in 256 ticks and outputs settle at 0; input -1 with gain 1 gives -1, confirming floor rounding.
- Assert system_reset asynchronously with 2 FIFO entries held and the FSM in MUL_R -> out_valid_o drops to 0 immediately, drop_cnt_o=0, gain_o=0, and no stale sample appears after release.
